// File: rtl/alu.sv
// 32-bit integer ALU for the EX stage of the MUSA single-issue core.
// Decodes the operation from alu_control (and func for R-type). The result,
// the {overflow, negative, zero} flags and the branch-taken bit are all
// registered, so every operation has a latency of one clock.
`timescale 1ns/1ps

module alu (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] data_a,
    input  logic [31:0] data_b,
    input  logic [2:0]  alu_control,
    input  logic [5:0]  func,
    output logic [31:0] result,
    output logic [2:0]  flag,
    output logic        branch
);

    // Decoded operation selectors
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOR  = 4'd5;
    localparam logic [3:0] OP_SLT  = 4'd6;
    localparam logic [3:0] OP_SLTU = 4'd7;
    localparam logic [3:0] OP_SLL  = 4'd8;
    localparam logic [3:0] OP_SRL  = 4'd9;
    localparam logic [3:0] OP_SRA  = 4'd10;
    localparam logic [3:0] OP_LUI  = 4'd11;
    localparam logic [3:0] OP_ZERO = 4'd12;

    logic [31:0] result_d, result_q;
    logic [2:0]  flag_d,   flag_q;
    logic        branch_d, branch_q;

    logic [3:0]  op_s;
    logic        br_eq_s;
    logic        br_ne_s;
    logic [31:0] sum_s;
    logic [31:0] diff_s;
    logic        add_ovf_s;
    logic        sub_ovf_s;
    logic        ovf_s;
    logic [4:0]  shamt_s;

    // Map alu_control / func onto one internal operation and branch condition
    always_comb begin
        op_s    = OP_ZERO;
        br_eq_s = 1'b0;
        br_ne_s = 1'b0;
        case (alu_control)
            3'd0: op_s = OP_ADD;
            3'd1: begin
                op_s    = OP_SUB;
                br_eq_s = 1'b1;
            end
            3'd2: begin
                case (func)
                    6'd0:    op_s = OP_ADD;
                    6'd1:    op_s = OP_SUB;
                    6'd2:    op_s = OP_AND;
                    6'd3:    op_s = OP_OR;
                    6'd4:    op_s = OP_XOR;
                    6'd5:    op_s = OP_NOR;
                    6'd6:    op_s = OP_SLT;
                    6'd7:    op_s = OP_SLTU;
                    6'd8:    op_s = OP_SLL;
                    6'd9:    op_s = OP_SRL;
                    6'd10:   op_s = OP_SRA;
                    default: op_s = OP_ZERO;
                endcase
            end
            3'd3: begin
                op_s    = OP_SUB;
                br_ne_s = 1'b1;
            end
            3'd4:    op_s = OP_AND;
            3'd5:    op_s = OP_OR;
            3'd6:    op_s = OP_SLT;
            3'd7:    op_s = OP_LUI;
            default: op_s = OP_ZERO;
        endcase
    end

    // Datapath: compute the result and overflow for the selected operation
    always_comb begin
        sum_s     = data_a + data_b;
        diff_s    = data_a - data_b;
        shamt_s   = data_b[4:0];
        add_ovf_s = (data_a[31] == data_b[31]) && (sum_s[31]  != data_a[31]);
        sub_ovf_s = (data_a[31] != data_b[31]) && (diff_s[31] != data_a[31]);
        result_d  = 32'h0000_0000;
        ovf_s     = 1'b0;
        case (op_s)
            OP_ADD: begin
                result_d = sum_s;
                ovf_s    = add_ovf_s;
            end
            OP_SUB: begin
                result_d = diff_s;
                ovf_s    = sub_ovf_s;
            end
            OP_AND:  result_d = data_a & data_b;
            OP_OR:   result_d = data_a | data_b;
            OP_XOR:  result_d = data_a ^ data_b;
            OP_NOR:  result_d = ~(data_a | data_b);
            OP_SLT:  result_d = {31'd0, ($signed(data_a) < $signed(data_b))};
            OP_SLTU: result_d = {31'd0, (data_a < data_b)};
            OP_SLL:  result_d = data_a << shamt_s;
            OP_SRL:  result_d = data_a >> shamt_s;
            OP_SRA:  result_d = $unsigned($signed(data_a) >>> shamt_s);
            OP_LUI:  result_d = {data_b[15:0], 16'h0000};
            default: result_d = 32'h0000_0000;
        endcase
    end

    // Flags and branch decision derived from this cycle's result and operands
    always_comb begin
        flag_d = {ovf_s, result_d[31], (result_d == 32'h0000_0000)};
        if (br_eq_s) begin
            branch_d = (data_a == data_b);
        end else if (br_ne_s) begin
            branch_d = (data_a != data_b);
        end else begin
            branch_d = 1'b0;
        end
    end

    // Output registers with synchronous reset that overrides any operation
    always_ff @(posedge clk) begin
        if (reset) begin
            result_q <= 32'h0000_0000;
            flag_q   <= 3'b000;
            branch_q <= 1'b0;
        end else begin
            result_q <= result_d;
            flag_q   <= flag_d;
            branch_q <= branch_d;
        end
    end

    assign result = result_q;
    assign flag   = flag_q;
    assign branch = branch_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: a table of directed vectors with hand-derived
// expectations, then random vectors checked against an independent model.
// Expected outputs go into a queue when stimulus is driven and are popped
// and compared one edge later.
`timescale 1ns/1ps

module tb_alu;

    logic        clk;
    logic        reset;
    logic [31:0] data_a;
    logic [31:0] data_b;
    logic [2:0]  alu_control;
    logic [5:0]  func;
    logic [31:0] result;
    logic [2:0]  flag;
    logic        branch;

    typedef struct {
        logic        rst;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  ctl;
        logic [5:0]  fn;
        logic [31:0] exp_result;
        logic [2:0]  exp_flag;
        logic        exp_branch;
    } vec_t;

    typedef struct {
        logic [31:0] r;
        logic [2:0]  f;
        logic        br;
        string       tag;
    } exp_t;

    localparam int NV = 28;
    localparam int NR = 200;

    vec_t vecs [NV];
    exp_t sb_q [$];
    int   checks;
    int   failures;

    alu dut (
        .clk         (clk),
        .reset       (reset),
        .data_a      (data_a),
        .data_b      (data_b),
        .alu_control (alu_control),
        .func        (func),
        .result      (result),
        .flag        (flag),
        .branch      (branch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic rst, input logic [31:0] a, input logic [31:0] b,
                                input logic [2:0] ctl, input logic [5:0] fn,
                                input logic [31:0] er, input logic [2:0] ef, input logic eb);
        vec_t v;
        v.rst = rst; v.a = a; v.b = b; v.ctl = ctl; v.fn = fn;
        v.exp_result = er; v.exp_flag = ef; v.exp_branch = eb;
        return v;
    endfunction

    // Independent reference: overflow from a 33-bit sign-extended computation
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic [2:0] ctl, input logic [5:0] fn);
        exp_t e;
        logic signed [32:0] wide;
        logic ovf;
        int   sel;
        e.r  = 32'd0;
        e.br = 1'b0;
        ovf  = 1'b0;
        wide = 33'sd0;
        if (ctl == 3'd2) sel = (fn <= 6'd10) ? int'(fn) : 99;
        else if (ctl == 3'd0) sel = 0;
        else if (ctl == 3'd1 || ctl == 3'd3) sel = 1;
        else if (ctl == 3'd4) sel = 2;
        else if (ctl == 3'd5) sel = 3;
        else if (ctl == 3'd6) sel = 6;
        else sel = 11;
        case (sel)
            0: begin
                wide = $signed({a[31], a}) + $signed({b[31], b});
                e.r = wide[31:0]; ovf = (wide[32] != wide[31]);
            end
            1: begin
                wide = $signed({a[31], a}) - $signed({b[31], b});
                e.r = wide[31:0]; ovf = (wide[32] != wide[31]);
            end
            2: e.r = a & b;
            3: e.r = a | b;
            4: e.r = a ^ b;
            5: e.r = ~(a | b);
            6: e.r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            7: e.r = (a < b) ? 32'd1 : 32'd0;
            8: e.r = a << b[4:0];
            9: e.r = a >> b[4:0];
            10: for (int i = 0; i < 32; i++)
                    e.r[i] = (i + int'(b[4:0]) > 31) ? a[31] : a[i + int'(b[4:0])];
            11: e.r = {b[15:0], 16'h0000};
            default: e.r = 32'd0;
        endcase
        if (ctl == 3'd1) e.br = (a == b);
        if (ctl == 3'd3) e.br = (a != b);
        e.f = {ovf, e.r[31], (e.r == 32'd0)};
        return e;
    endfunction

    task automatic drive_and_check(input logic rst, input logic [31:0] a, input logic [31:0] b,
                                   input logic [2:0] ctl, input logic [5:0] fn, input exp_t e);
        exp_t got;
        reset = rst; data_a = a; data_b = b; alu_control = ctl; func = fn;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        checks++;
        if (result !== got.r) begin
            failures++;
            $display("FAIL %s result actual=%08h required=%08h", got.tag, result, got.r);
        end
        checks++;
        if (flag !== got.f) begin
            failures++;
            $display("FAIL %s flag actual=%03b required=%03b", got.tag, flag, got.f);
        end
        checks++;
        if (branch !== got.br) begin
            failures++;
            $display("FAIL %s branch actual=%0b required=%0b", got.tag, branch, got.br);
        end
    endtask

    initial begin
        exp_t e;
        logic [31:0] ra, rb;
        logic [2:0]  rc;
        logic [5:0]  rf;
        checks = 0;
        failures = 0;
        reset = 1'b1; data_a = 32'd0; data_b = 32'd0; alu_control = 3'd0; func = 6'd0;

        vecs[0]  = mk(1'b1, 32'hDEADBEEF, 32'h12345678, 3'd0, 6'd0,  32'h00000000, 3'b000, 1'b0);
        vecs[1]  = mk(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'd1, 6'd0,  32'h00000000, 3'b000, 1'b0);
        vecs[2]  = mk(1'b0, 32'hFFFFFFFF, 32'h00000000, 3'd2, 6'd1,  32'hFFFFFFFF, 3'b010, 1'b0);
        vecs[3]  = mk(1'b0, 32'h7FFFFFFF, 32'h00000001, 3'd0, 6'd0,  32'h80000000, 3'b110, 1'b0);
        vecs[4]  = mk(1'b0, 32'hFFFFFFFF, 32'h00000001, 3'd0, 6'd0,  32'h00000000, 3'b001, 1'b0);
        vecs[5]  = mk(1'b0, 32'h00000005, 32'h00000005, 3'd1, 6'd0,  32'h00000000, 3'b001, 1'b1);
        vecs[6]  = mk(1'b0, 32'h00000005, 32'h00000005, 3'd3, 6'd0,  32'h00000000, 3'b001, 1'b0);
        vecs[7]  = mk(1'b0, 32'h80000000, 32'h00000004, 3'd2, 6'd10, 32'hF8000000, 3'b010, 1'b0);
        vecs[8]  = mk(1'b0, 32'h80000000, 32'h00000004, 3'd2, 6'd9,  32'h08000000, 3'b000, 1'b0);
        vecs[9]  = mk(1'b0, 32'h00000001, 32'hFFFFFFFF, 3'd2, 6'd7,  32'h00000001, 3'b000, 1'b0);
        vecs[10] = mk(1'b0, 32'h00000001, 32'hFFFFFFFF, 3'd2, 6'd6,  32'h00000000, 3'b001, 1'b0);
        vecs[11] = mk(1'b0, 32'h12345678, 32'h00000009, 3'd2, 6'd63, 32'h00000000, 3'b001, 1'b0);
        vecs[12] = mk(1'b0, 32'h00000001, 32'h00000001, 3'd0, 6'd0,  32'h00000002, 3'b000, 1'b0);
        vecs[13] = mk(1'b1, 32'h00000003, 32'h00000004, 3'd0, 6'd0,  32'h00000000, 3'b000, 1'b0);
        vecs[14] = mk(1'b0, 32'h00000003, 32'h00000004, 3'd0, 6'd0,  32'h00000007, 3'b000, 1'b0);
        vecs[15] = mk(1'b0, 32'h00000005, 32'h00000006, 3'd3, 6'd0,  32'hFFFFFFFF, 3'b010, 1'b1);
        vecs[16] = mk(1'b0, 32'h80000000, 32'h00000001, 3'd1, 6'd0,  32'h7FFFFFFF, 3'b100, 1'b0);
        vecs[17] = mk(1'b0, 32'hFFFFFFFF, 32'h0000ABCD, 3'd7, 6'd0,  32'hABCD0000, 3'b010, 1'b0);
        vecs[18] = mk(1'b0, 32'hFFFFFFFF, 32'h00000000, 3'd6, 6'd0,  32'h00000001, 3'b000, 1'b0);
        vecs[19] = mk(1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 3'd4, 6'd0,  32'hF000F000, 3'b010, 1'b0);
        vecs[20] = mk(1'b0, 32'h0F0F0000, 32'h000000F0, 3'd5, 6'd0,  32'h0F0F00F0, 3'b000, 1'b0);
        vecs[21] = mk(1'b0, 32'hFFFF0000, 32'hFF00FF00, 3'd2, 6'd4,  32'h00FFFF00, 3'b000, 1'b0);
        vecs[22] = mk(1'b0, 32'h00000000, 32'h00000000, 3'd2, 6'd5,  32'hFFFFFFFF, 3'b010, 1'b0);
        vecs[23] = mk(1'b0, 32'h80000000, 32'h80000000, 3'd2, 6'd0,  32'h00000000, 3'b101, 1'b0);
        vecs[24] = mk(1'b0, 32'hAAAA5555, 32'h0F0F0F0F, 3'd2, 6'd2,  32'h0A0A0505, 3'b000, 1'b0);
        vecs[25] = mk(1'b0, 32'h00000000, 32'h00000000, 3'd2, 6'd3,  32'h00000000, 3'b001, 1'b0);
        vecs[26] = mk(1'b0, 32'h00000001, 32'h0000003F, 3'd2, 6'd8,  32'h80000000, 3'b010, 1'b0);
        vecs[27] = mk(1'b0, 32'h00000001, 32'h00000001, 3'd2, 6'd11, 32'h00000000, 3'b001, 1'b0);

        @(negedge clk);
        for (int i = 0; i < NV; i++) begin
            e.r = vecs[i].exp_result;
            e.f = vecs[i].exp_flag;
            e.br = vecs[i].exp_branch;
            e.tag = $sformatf("vec%0d", i);
            drive_and_check(vecs[i].rst, vecs[i].a, vecs[i].b, vecs[i].ctl, vecs[i].fn, e);
        end

        // Reset landing in a back-to-back ADD stream after a nonzero result
        e.r = 32'h00000064; e.f = 3'b000; e.br = 1'b0; e.tag = "seq_pre";
        drive_and_check(1'b0, 32'd60, 32'd40, 3'd0, 6'd0, e);
        e.r = 32'h00000000; e.f = 3'b000; e.br = 1'b0; e.tag = "seq_rst";
        drive_and_check(1'b1, 32'd10, 32'd20, 3'd0, 6'd0, e);
        e.r = 32'h0000001E; e.f = 3'b000; e.br = 1'b0; e.tag = "seq_resume";
        drive_and_check(1'b0, 32'd10, 32'd20, 3'd0, 6'd0, e);

        // Random operations against the reference model
        for (int i = 0; i < NR; i++) begin
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
            rc = 3'($urandom_range(0, 7));
            rf = 6'($urandom_range(0, 15));
            e = model(ra, rb, rc, rf);
            e.tag = $sformatf("rnd%0d", i);
            drive_and_check(1'b0, ra, rb, rc, rf, e);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
